// File: rtl/apuf_eval_ctrl_if.sv
// Challenge/response bundle between the host command layer, the evaluation
// sequencer and the arbiter PUF it drives.
interface apuf_eval_ctrl_if #(
  parameter int CHAL_W = 64,
  parameter int CNT_W  = 4
);
  logic [CHAL_W-1:0] chal_in;
  logic              chal_valid;
  logic              chal_ready;
  logic [CHAL_W-1:0] c;
  logic              tigSignal;
  logic              respReady;
  logic              respBit;
  logic              resp_valid;
  logic              resp_bit;
  logic [CNT_W-1:0]  ones_cnt;
  logic              timeout;

  // master: host plus APUF side; slave: the sequencer
  modport master (
    output chal_in, chal_valid, respReady, respBit,
    input  chal_ready, c, tigSignal, resp_valid, resp_bit, ones_cnt, timeout
  );
  modport slave (
    input  chal_in, chal_valid, respReady, respBit,
    output chal_ready, c, tigSignal, resp_valid, resp_bit, ones_cnt, timeout
  );
endinterface

// File: rtl/apuf_eval_ctrl.sv
// Evaluation sequencer for one classic arbiter PUF: holds the challenge, fires the
// trigger NUM_EVAL times with settle/relax gaps and majority-votes the responses.
module apuf_eval_ctrl #(
  parameter int CHAL_W      = 64,
  parameter int NUM_EVAL    = 15,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk,
  input logic             rst,
  apuf_eval_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_EVAL + 1);
  localparam int SET_W = $clog2(SETTLE_CYC) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, SETTLE, FIRE, WAIT, RELAX, DONE} evalState_t;

  evalState_t        state;
  logic [CHAL_W-1:0] cReg;
  logic              tig;
  logic              respValid;
  logic              respBitReg;
  logic [CNT_W-1:0]  onesCnt;
  logic              timeoutReg;
  logic [CNT_W-1:0]  evalCnt;
  logic [SET_W-1:0]  settleCnt;
  logic [TO_W-1:0]   toCnt;

  // NUM_EVAL is odd, so a strict "more than half" never ties
  function automatic logic majority(input logic [CNT_W-1:0] ones);
    return ones > CNT_W'(NUM_EVAL / 2);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cReg       <= '0;
      tig        <= 1'b0;
      respValid  <= 1'b0;
      respBitReg <= 1'b0;
      onesCnt    <= '0;
      timeoutReg <= 1'b0;
      evalCnt    <= '0;
      settleCnt  <= '0;
      toCnt      <= '0;
    end else begin
      respValid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.chal_valid) begin
            cReg       <= bus.chal_in;
            onesCnt    <= '0;
            timeoutReg <= 1'b0;
            respBitReg <= 1'b0;
            evalCnt    <= '0;
            settleCnt  <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          tig <= 1'b0;
          if (settleCnt == SET_W'(SETTLE_CYC - 1)) state <= FIRE;
          else settleCnt <= settleCnt + SET_W'(1);
        end
        FIRE: begin
          tig       <= 1'b1;
          toCnt     <= '0;
          settleCnt <= '0;
          state     <= WAIT;
        end
        // a response on the final timeout cycle takes priority over the abort
        WAIT: begin
          if (bus.respReady) begin
            onesCnt <= onesCnt + CNT_W'(bus.respBit);
            evalCnt <= evalCnt + CNT_W'(1);
            state   <= RELAX;
          end else if (toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
            timeoutReg <= 1'b1;
            respBitReg <= 1'b0;
            respValid  <= 1'b1;
            state      <= DONE;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
        end
        RELAX: begin
          tig <= 1'b0;
          if (!bus.respReady) begin
            if (evalCnt == CNT_W'(NUM_EVAL)) begin
              respBitReg <= majority(onesCnt);
              respValid  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          tig   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.chal_ready = (state == IDLE);
  assign bus.c          = cReg;
  assign bus.tigSignal  = tig;
  assign bus.resp_valid = respValid;
  assign bus.resp_bit   = respBitReg;
  assign bus.ones_cnt   = onesCnt;
  assign bus.timeout    = timeoutReg;
endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl: a scripted APUF responder plus a
// cycle-count/majority reference model computed from the evaluation rules.
module tb_apuf_eval_ctrl;
  localparam int SET = 4;
  localparam int TO  = 10;
  localparam int NE  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apuf_eval_ctrl_if #(.CHAL_W(64), .CNT_W(4)) bus ();
  apuf_eval_ctrl_if #(.CHAL_W(64), .CNT_W(1)) bus1 ();

  apuf_eval_ctrl #(.CHAL_W(64), .NUM_EVAL(NE), .SETTLE_CYC(SET), .TIMEOUT_CYC(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));
  apuf_eval_ctrl #(.CHAL_W(64), .NUM_EVAL(1), .SETTLE_CYC(SET), .TIMEOUT_CYC(TO))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  // responder script: per evaluation, delay after the trigger rise, hold length, bit
  int rDelay[$];
  int rHold[$];
  bit rBit[$];
  int rIdx  = 0;
  int phase = 0;
  int cnt   = 0;

  bit         prevTig = 1'b0;
  int         rises   = 0;
  int         riseCyc = -1;
  int         vldCnt  = 0;
  int         vldCyc  = -1;
  logic       vBit;
  logic [3:0] vOnes;
  logic       vTo;

  typedef struct {
    int hs; int vld; bit seen; int rises; int lastRise;
    logic rb; logic [3:0] ones; logic to; logic [63:0] cDone;
    logic rdyHs; logic tigAfter; logic rdyAfter; logic vldAfter;
    int extraRises; int pulses;
  } obs_t;

  // one clock: observe at the falling edge, then update the APUF model's inputs
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (bus.tigSignal && !prevTig) begin rises++; riseCyc = cyc; end
    prevTig = bus.tigSignal;
    if (bus.resp_valid) begin
      vldCnt++; vldCyc = cyc;
      vBit = bus.resp_bit; vOnes = bus.ones_cnt; vTo = bus.timeout;
    end
    if (rst) begin
      bus.respReady = 1'b0; phase = 0;
    end else begin
      if (phase == 0 && riseCyc == cyc && rIdx < rDelay.size()) begin
        cnt = rDelay[rIdx]; phase = 1;
      end
      if (phase == 1) begin
        if (cnt == 0) begin
          bus.respReady = 1'b1; bus.respBit = rBit[rIdx];
          cnt = rHold[rIdx]; rIdx++; phase = 2;
        end else if (cnt > 0) cnt--;
      end else if (phase == 2) begin
        if (cnt <= 1) begin
          bus.respReady = 1'b0; bus.respBit = 1'($urandom); phase = 0;
        end else cnt--;
      end
    end
  endtask

  task automatic planFill(input int nOnes, input int dMax, input int hMax);
    rDelay.delete(); rHold.delete(); rBit.delete();
    for (int i = 0; i < NE; i++) begin
      rDelay.push_back(int'($urandom_range(dMax, 0)));
      rHold.push_back(int'($urandom_range(hMax, 1)));
      rBit.push_back(nOnes < 0 ? 1'($urandom) : (i < nOnes));
    end
    if (nOnes >= 0)
      for (int i = NE - 1; i > 0; i--) begin
        int j = int'($urandom_range(i, 0));
        bit tmp = rBit[i];
        rBit[i] = rBit[j]; rBit[j] = tmp;
      end
  endtask

  // Reference: each evaluation costs settle + fire + (delay+1) wait + hold relax
  // cycles; a response that would need more than TO wait cycles aborts instead.
  task automatic model(output int lat, output int ones, output bit rb, output bit to,
                       output int nRise);
    lat = 1; ones = 0; to = 1'b0; nRise = 0;
    for (int i = 0; i < rDelay.size(); i++) begin
      nRise++;
      if (rDelay[i] < 0 || rDelay[i] >= TO) begin
        lat += SET + 1 + TO; to = 1'b1; break;
      end
      lat += SET + 1 + rDelay[i] + 1 + rHold[i];
      ones += int'(rBit[i]);
    end
    rb = !to && (ones > NE / 2);
  endtask

  task automatic evalRun(input logic [63:0] ch, input bit junk, output obs_t o);
    int v0;
    rIdx = 0; phase = 0; rises = 0; v0 = vldCnt;
    bus.respReady = 1'b0;
    o.rdyHs = bus.chal_ready; o.hs = cyc;
    bus.chal_in = ch; bus.chal_valid = 1'b1;
    cycle();
    if (junk) bus.chal_in = ~ch; else bus.chal_valid = 1'b0;
    for (int i = 0; i < 800 && vldCnt == v0; i++) cycle();
    bus.chal_valid = 1'b0;
    o.seen = (vldCnt != v0); o.vld = vldCyc; o.rises = rises; o.lastRise = riseCyc;
    o.rb = vBit; o.ones = vOnes; o.to = vTo; o.cDone = bus.c;
    cycle();
    o.tigAfter = bus.tigSignal; o.rdyAfter = bus.chal_ready; o.vldAfter = bus.resp_valid;
    repeat (3) cycle();
    o.extraRises = rises - o.rises; o.pulses = vldCnt - v0;
  endtask

  task automatic test_reset();
    bus.chal_valid = 1'b1; bus.chal_in = {$urandom, $urandom};
    bus1.chal_valid = 1'b1; bus1.chal_in = {$urandom, $urandom};
    repeat (3) cycle();
    nChecks++;
    if ({bus.c, bus.tigSignal, bus.resp_valid, bus.resp_bit, bus.ones_cnt, bus.timeout} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: c=%h tig=%b vld=%b bit=%b ones=%0d to=%b, required all 0",
               bus.c, bus.tigSignal, bus.resp_valid, bus.resp_bit, bus.ones_cnt, bus.timeout);
    end
    rst = 1'b0; bus.chal_valid = 1'b0; bus1.chal_valid = 1'b0;
    cycle();
    nChecks++;
    if (bus.chal_ready !== 1'b1 || bus1.chal_ready !== 1'b1) begin
      nFail++;
      $display("FAIL reset_ready: chal_ready=%b/%b, required 1/1", bus.chal_ready, bus1.chal_ready);
    end
    repeat (8) cycle();
    nChecks++;
    if (bus.c !== 64'h0 || rises !== 0 || bus1.tigSignal !== 1'b0) begin
      nFail++;
      $display("FAIL reset_no_accept: c=%h rises=%0d, required 0 and 0", bus.c, rises);
    end
  endtask

  task automatic test_single();
    logic [63:0] ch = 64'hDEADBEEF_01234567;
    int hs, t, v;
    logic rb, ones, to;
    rb = 1'b0; ones = 1'b0; to = 1'b1;
    bus1.chal_in = ch; bus1.chal_valid = 1'b1; hs = cyc;
    cycle();
    bus1.chal_valid = 1'b0;
    nChecks++;
    if (bus1.c !== ch) begin
      nFail++; $display("FAIL single_c: c=%h, required %h", bus1.c, ch);
    end
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      if (bus1.tigSignal) t = cyc; else cycle();
    end
    nChecks++;
    if (t - hs !== SET + 2) begin
      nFail++; $display("FAIL single_rise: rise %0d cycles after handshake, required %0d", t - hs, SET + 2);
    end
    cycle();
    bus1.respReady = 1'b1; bus1.respBit = 1'b1;
    cycle();
    bus1.respReady = 1'b0;
    v = -1;
    for (int i = 0; i < 20 && v < 0; i++) begin
      if (bus1.resp_valid) begin
        v = cyc; rb = bus1.resp_bit; ones = bus1.ones_cnt; to = bus1.timeout;
      end else cycle();
    end
    nChecks++;
    if (v - t !== 3) begin
      nFail++; $display("FAIL single_latency: resp_valid %0d cycles after rise, required 3", v - t);
    end
    nChecks++;
    if (rb !== 1'b1 || ones !== 1'b1 || to !== 1'b0) begin
      nFail++; $display("FAIL single_result: bit=%b ones=%b to=%b, required 1 1 0", rb, ones, to);
    end
  endtask

  task automatic test_majority();
    obs_t o; int lat, ones, nr; bit rb, to;
    for (int k = 0; k < 2; k++) begin
      planFill(k == 0 ? 8 : 7, 3, 2);
      model(lat, ones, rb, to, nr);
      evalRun({$urandom, $urandom}, 1'b0, o);
      nChecks++;
      if (o.rb !== rb || o.ones !== 4'(ones) || o.to !== to) begin
        nFail++;
        $display("FAIL majority_%0d: bit=%b ones=%0d to=%b, required %b %0d %b", k, o.rb, o.ones, o.to, rb, ones, to);
      end
      nChecks++;
      if (o.rises !== nr) begin
        nFail++; $display("FAIL majority_rises: %0d trigger rises, required %0d", o.rises, nr);
      end
      nChecks++;
      if (!o.seen || o.vld - o.hs !== lat) begin
        nFail++; $display("FAIL majority_latency: seen=%b lat=%0d, required %0d", o.seen, o.vld - o.hs, lat);
      end
    end
  endtask

  task automatic test_random();
    obs_t o; int lat, ones, nr; bit rb, to;
    for (int k = 0; k < 3; k++) begin
      planFill(-1, 5, 3);
      model(lat, ones, rb, to, nr);
      evalRun({$urandom, $urandom}, 1'b0, o);
      nChecks++;
      if (!o.seen || o.vld - o.hs !== lat || o.rb !== rb || o.ones !== 4'(ones) || o.rises !== nr) begin
        nFail++;
        $display("FAIL random_%0d: lat=%0d bit=%b ones=%0d rises=%0d, required %0d %b %0d %0d",
                 k, o.vld - o.hs, o.rb, o.ones, o.rises, lat, rb, ones, nr);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o; int lat, ones, nr; bit rb, to;
    planFill(-1, 3, 2);
    rDelay[$urandom_range(4, 0)] = -1;
    model(lat, ones, rb, to, nr);
    evalRun({$urandom, $urandom}, 1'b0, o);
    nChecks++;
    if (!o.seen || o.vld - o.lastRise !== TO || o.vld - o.hs !== lat) begin
      nFail++;
      $display("FAIL timeout_latency: %0d cycles after rise (total %0d), required %0d (total %0d)",
               o.vld - o.lastRise, o.vld - o.hs, TO, lat);
    end
    nChecks++;
    if (o.to !== 1'b1 || o.rb !== 1'b0 || o.ones !== 4'(ones)) begin
      nFail++; $display("FAIL timeout_result: to=%b bit=%b ones=%0d, required 1 0 %0d", o.to, o.rb, o.ones, ones);
    end
    nChecks++;
    if (o.tigAfter !== 1'b0 || o.rdyAfter !== 1'b1 || o.vldAfter !== 1'b0) begin
      nFail++;
      $display("FAIL timeout_after: tig=%b ready=%b vld=%b, required 0 1 0", o.tigAfter, o.rdyAfter, o.vldAfter);
    end
  endtask

  task automatic test_collision();
    obs_t o; int lat, ones, nr; bit rb, to;
    planFill(-1, 2, 1);
    rDelay[0] = TO - 1; rDelay[6] = TO - 1; rDelay[14] = TO - 1;
    model(lat, ones, rb, to, nr);
    evalRun({$urandom, $urandom}, 1'b0, o);
    nChecks++;
    if (o.to !== 1'b0 || o.ones !== 4'(ones) || o.rb !== rb) begin
      nFail++; $display("FAIL collision_result: to=%b ones=%0d bit=%b, required 0 %0d %b", o.to, o.ones, o.rb, ones, rb);
    end
    nChecks++;
    if (!o.seen || o.vld - o.hs !== lat || o.rises !== NE) begin
      nFail++; $display("FAIL collision_timing: lat=%0d rises=%0d, required %0d %0d", o.vld - o.hs, o.rises, lat, NE);
    end
  endtask

  task automatic test_sticky();
    obs_t o; int lat, ones, nr; bit rb, to;
    planFill(-1, 1, 1);
    rHold[3] = 6; rHold[10] = 6;
    model(lat, ones, rb, to, nr);
    evalRun({$urandom, $urandom}, 1'b0, o);
    nChecks++;
    if (!o.seen || o.vld - o.hs !== lat || o.rises !== nr || o.ones !== 4'(ones)) begin
      nFail++;
      $display("FAIL sticky_ready: lat=%0d rises=%0d ones=%0d, required %0d %0d %0d", o.vld - o.hs, o.rises, o.ones, lat, nr, ones);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; int lat, ones, nr; bit rb, to;
    logic [63:0] ch;
    for (int k = 0; k < 2; k++) begin
      ch = {$urandom, $urandom};
      planFill(-1, 2, 2);
      model(lat, ones, rb, to, nr);
      evalRun(ch, 1'b1, o);
      nChecks++;
      if (o.rdyHs !== 1'b1 || o.cDone !== ch || o.extraRises !== 0 || o.pulses !== 1) begin
        nFail++;
        $display("FAIL b2b_ignore_%0d: ready=%b c=%h extra_rises=%0d pulses=%0d, required 1 %h 0 1",
                 k, o.rdyHs, o.cDone, o.extraRises, o.pulses, ch);
      end
      nChecks++;
      if (!o.seen || o.vld - o.hs !== lat || o.rb !== rb || o.rdyAfter !== 1'b1) begin
        nFail++;
        $display("FAIL b2b_result_%0d: lat=%0d bit=%b ready_after=%b, required %0d %b 1", k, o.vld - o.hs, o.rb, o.rdyAfter, lat, rb);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    rDelay.delete(); rHold.delete(); rBit.delete();
    for (int i = 0; i < NE; i++) begin rDelay.push_back(-1); rHold.push_back(1); rBit.push_back(1'b1); end
    rIdx = 0; phase = 0; v0 = vldCnt;
    bus.chal_in = {$urandom, $urandom} | 64'h1; bus.chal_valid = 1'b1;
    cycle();
    bus.chal_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.tigSignal; i++) cycle();
    nChecks++;
    if (bus.tigSignal !== 1'b1) begin
      nFail++; $display("FAIL rstmid_reach_wait: tig=%b, required 1", bus.tigSignal);
    end
    rst = 1'b1;
    cycle();
    nChecks++;
    if (bus.tigSignal !== 1'b0 || bus.c !== 64'h0 || bus.resp_valid !== 1'b0) begin
      nFail++; $display("FAIL rstmid_clear: tig=%b c=%h vld=%b, required 0 0 0", bus.tigSignal, bus.c, bus.resp_valid);
    end
    rst = 1'b0;
    repeat (TO + 6) cycle();
    nChecks++;
    if (vldCnt !== v0 || bus.chal_ready !== 1'b1) begin
      nFail++; $display("FAIL rstmid_no_pulse: pulses=%0d ready=%b, required 0 1", vldCnt - v0, bus.chal_ready);
    end
  endtask

  initial begin
    bus.chal_in = '0; bus.chal_valid = 1'b0; bus.respReady = 1'b0; bus.respBit = 1'b0;
    bus1.chal_in = '0; bus1.chal_valid = 1'b0; bus1.respReady = 1'b0; bus1.respBit = 1'b0;
    test_reset();
    test_single();
    test_majority();
    test_random();
    test_timeout();
    test_collision();
    test_sticky();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/apuf_eval_ctrl.md
# apuf_eval_ctrl

Evaluation sequencer for one classic arbiter PUF instance (`apufClassic`). It accepts a 64-bit challenge over a valid/ready handshake and drives it onto the PUF challenge bus. It then fires the PUF trigger `NUM_EVAL` times, with a settle and relax phase around each shot, and reduces the collected response bits to a majority-voted response plus a ones count. It sits between the host/UART command layer and the APUF, and it is the only driver of the APUF's `c` and `tigSignal` inputs.

## Interface
Parameters:
- `CHAL_W`, 64, challenge width; must match the APUF stage count.
- `NUM_EVAL`, 15, evaluations per challenge; odd, ≥1, so a majority tie cannot occur.
- `SETTLE_CYC`, 4, cycles `c` is held stable with the trigger low before each fire; ≥1.
- `TIMEOUT_CYC`, 255, maximum WAIT cycles before abort; ≥1.
- `CNT_W`, derived: `$clog2(NUM_EVAL+1)`.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high; all state changes on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `chal_in` in CHAL_W: challenge, sampled when `chal_valid & chal_ready`.
- `chal_valid` in 1: challenge offered.
- `chal_ready` out 1: high only in IDLE.
- `c` out CHAL_W: challenge to the APUF (registered).
- `tigSignal` out 1: APUF trigger (registered).
- `respReady` in 1: APUF response valid.
- `respBit` in 1: APUF arbiter output.
- `resp_valid` out 1: one-cycle pulse, result available.
- `resp_bit` out 1: majority response.
- `ones_cnt` out CNT_W: number of evaluations that returned 1.
- `timeout` out 1: set if the APUF failed to respond.

## Operation
States: IDLE, SETTLE, FIRE, WAIT, RELAX, DONE. `rst` forces IDLE.

- **Reset values:** `c`=0, `tigSignal`=0, `resp_valid`=0, `resp_bit`=0, `ones_cnt`=0, `timeout`=0. `chal_ready`=1 in the first cycle after `rst` deasserts.
- **IDLE:** `chal_ready`=1. On a handshake:
  - `c` ← `chal_in`.
  - `ones_cnt`, `timeout`, `resp_bit` and the eval counter all clear.
  - Next state SETTLE.
- **SETTLE:** `tigSignal`=0. Stays exactly `SETTLE_CYC` cycles, then goes to FIRE.
- **FIRE:** one cycle. Sets `tigSignal`←1 and clears the timeout counter. Next state WAIT.
- **WAIT:** `tigSignal` held at 1.
  - If `respReady`=1: `ones_cnt` += `respBit`, eval count += 1, next state RELAX.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT_CYC`: `timeout`←1, next state DONE.
- **RELAX:** `tigSignal`←0. Stays at least 1 cycle and until `respReady`=0. Then:
  - DONE if eval count == `NUM_EVAL`;
  - SETTLE otherwise.
- **DONE:** one cycle.
  - `resp_valid`=1.
  - `resp_bit` = (`ones_cnt` > `NUM_EVAL`/2) when `timeout`=0; forced to 0 when `timeout`=1.
  - Next state IDLE.
- **Held values:** `c` holds its value through IDLE after DONE. `resp_bit`, `ones_cnt` and `timeout` hold until the next handshake.
- **Boundary rules:**
  - `chal_valid` outside IDLE is ignored and not queued.
  - `respReady` outside WAIT is ignored.
  - If `respReady` is high in the same cycle the timeout count is reached, the response wins and no timeout is flagged.
  - On timeout, `ones_cnt` retains the partial count.
  - `rst` mid-evaluation returns to IDLE on the next edge with `tigSignal`=0 and `c`=0, and produces no `resp_valid` pulse.
  - `ones_cnt` never exceeds `NUM_EVAL`; no wrap is possible at width `CNT_W`.

## Timing
- Handshake cycle T0 → SETTLE at T1 → `c` valid at the APUF from T1.
- **Per evaluation:** `SETTLE_CYC` + 1 (FIRE) + w + r cycles.
  - w = WAIT cycles, including the cycle in which `respReady` is sampled; w ≥ 1.
  - r = RELAX cycles; r ≥ 1.
- **Rising edge of `tigSignal`:** visible the cycle after FIRE.
- **Response-ready to result:** `resp_valid` pulses in the DONE cycle, which is the cycle after the final RELAX exit.
- **Next challenge:** `chal_ready` returns the cycle after DONE, so the minimum challenge-to-challenge spacing is that total + 2.
- **Timeout path:** `resp_valid` pulses exactly `TIMEOUT_CYC` + 1 cycles after the FIRE cycle (WAIT lasts `TIMEOUT_CYC` cycles, then one DONE cycle).
- **Output registration:** all outputs are registered except `chal_ready`, which is decoded from state.

## Test plan
- **Reset:** hold `rst` for 3 cycles, then release → all outputs 0, `chal_ready`=1; `chal_valid`=1 during reset is not accepted.
- **Single evaluation:** `NUM_EVAL`=1, `SETTLE_CYC`=4, challenge `0xDEADBEEF_01234567`; model asserts `respReady` 1 cycle after `tigSignal` rises, with `respBit`=1 → `c` matches, exactly 4 low-trigger cycles precede the rise, then `resp_valid` pulse with `resp_bit`=1, `ones_cnt`=1.
- **Majority vote:** `NUM_EVAL`=15; model returns 8 ones and 7 zeros → `resp_bit`=1, `ones_cnt`=8. With 7 ones → `resp_bit`=0, `ones_cnt`=7. Check there are exactly 15 `tigSignal` rising edges.
- **Timeout:** model never asserts `respReady`, `TIMEOUT_CYC`=10 → `resp_valid` 11 cycles after FIRE, `timeout`=1, `resp_bit`=0, `tigSignal` returns to 0 and `chal_ready`=1 next cycle.
- **Response/timeout collision:** `respReady` arrives on the exact timeout cycle → `timeout`=0 and the evaluation is counted.
- **Sticky ready and reset mid-run:**
  - Model holds `respReady` high 5 cycles into RELAX → no new FIRE until it drops.
  - Assert `rst` during WAIT → `tigSignal`=0 and `c`=0 on the next edge, and no `resp_valid` pulse.
